// File: rtl/accum_core_p.sv
// rtl/accum_core_p.sv - multi-cycle accumulator processor core with data RAM and return stack
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   rom_addr   program ROM address (equals pc)
//   rom_data   instruction word from asynchronous-read ROM
//   indata     input port, sampled by IN
//   outdata    output register, written by OUT
//   out_valid  one-cycle pulse following an OUT
//   acc_value  debug view of the accumulator
//   pc_value   debug view of the program counter
//   ir_value   debug view of the instruction register
//   carry      carry/borrow flag
//   halted     high while in HALT
//   fault      sticky return-stack error flag
module accum_core_p #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int RAW = 6,
    parameter int SD  = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW+4:0]   rom_data,
    input  logic [DW-1:0]   indata,
    output logic [DW-1:0]   outdata,
    output logic            out_valid,
    output logic [DW-1:0]   acc_value,
    output logic [AW-1:0]   pc_value,
    output logic [DW+4:0]   ir_value,
    output logic            carry,
    output logic            halted,
    output logic            fault
);

    localparam int IW    = DW + 5;
    localparam int SPW   = $clog2(SD + 1);
    // Stack depth rounded up to a power of two so the entry count indexes it
    // directly; entries at SD and above are never written.
    localparam int STK_N = 1 << SPW;
    localparam int RAM_N = 1 << RAW;

    localparam logic [DW-1:0]  DW_V = DW'(DW);
    localparam logic [SPW-1:0] SD_V = SPW'(SD);

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR   = 5'h04;
    localparam logic [4:0] OP_SHL   = 5'h05;
    localparam logic [4:0] OP_SHR   = 5'h06;
    localparam logic [4:0] OP_COMP  = 5'h07;
    localparam logic [4:0] OP_ADDI  = 5'h08;
    localparam logic [4:0] OP_SUBI  = 5'h09;
    localparam logic [4:0] OP_ANDI  = 5'h0A;
    localparam logic [4:0] OP_ORI   = 5'h0B;
    localparam logic [4:0] OP_XORI  = 5'h0C;
    localparam logic [4:0] OP_SHLI  = 5'h0D;
    localparam logic [4:0] OP_SHRI  = 5'h0E;
    localparam logic [4:0] OP_LDA   = 5'h10;
    localparam logic [4:0] OP_LDI   = 5'h11;
    localparam logic [4:0] OP_STA   = 5'h12;
    localparam logic [4:0] OP_GOTO  = 5'h15;
    localparam logic [4:0] OP_SKIFZ = 5'h16;
    localparam logic [4:0] OP_SKIFN = 5'h17;
    localparam logic [4:0] OP_SKIFC = 5'h18;
    localparam logic [4:0] OP_CALL  = 5'h1A;
    localparam logic [4:0] OP_RET   = 5'h1B;
    localparam logic [4:0] OP_IN    = 5'h1D;
    localparam logic [4:0] OP_OUT   = 5'h1E;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_SYNC,
        ST_HALT
    } state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [IW-1:0]   ir;
    logic [DW-1:0]   acc;
    logic [SPW-1:0]  sp;
    logic [AW-1:0]   stack [STK_N];
    logic [DW-1:0]   ram   [RAM_N];

    logic [4:0]      op;
    logic [DW-1:0]   operand;
    logic [DW-1:0]   mem;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_res;
    logic            alu_carry;
    logic [DW:0]     sum;
    logic [DW:0]     diff;
    logic            skip_take;

    assign rom_addr  = pc;
    assign pc_value  = pc;
    assign ir_value  = ir;
    assign acc_value = acc;

    // Opcodes 00-07 and 08-0E share one ALU: bit 3 selects the immediate
    // operand, bits 2:0 select the function. alu_carry holds the old flag
    // for everything except the add/subtract pair.
    always_comb begin
        op        = ir[IW-1:DW];
        operand   = ir[DW-1:0];
        mem       = ram[ir[RAW-1:0]];
        alu_b     = op[3] ? operand : mem;
        sum       = {1'b0, acc} + {1'b0, alu_b};
        diff      = {1'b0, acc} - {1'b0, alu_b};
        alu_res   = '0;
        alu_carry = carry;
        case (op[2:0])
            3'd0: begin
                alu_res   = sum[DW-1:0];
                alu_carry = sum[DW];
            end
            3'd1: begin
                alu_res   = diff[DW-1:0];
                alu_carry = diff[DW];
            end
            3'd2:    alu_res = acc & alu_b;
            3'd3:    alu_res = acc | alu_b;
            3'd4:    alu_res = acc ^ alu_b;
            3'd5:    alu_res = (alu_b >= DW_V) ? '0 : (acc << alu_b);
            3'd6:    alu_res = (alu_b >= DW_V) ? '0 : (acc >> alu_b);
            default: alu_res = ~acc;
        endcase
    end

    always_comb begin
        skip_take = 1'b0;
        case (op)
            OP_SKIFZ: skip_take = (acc == '0);
            OP_SKIFN: skip_take = acc[DW-1];
            OP_SKIFC: skip_take = carry;
            default:  skip_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            outdata   <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            fault     <= 1'b0;
            halted    <= 1'b0;
            sp        <= '0;
            for (int i = 0; i < STK_N; i++) begin
                stack[i] <= '0;
            end
            for (int i = 0; i < RAM_N; i++) begin
                ram[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_INIT: state <= ST_FETCH;
                ST_FETCH: begin
                    ir    <= rom_data;
                    pc    <= pc + AW'(1);
                    state <= ST_DECODE;
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
                        OP_COMP, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI,
                        OP_SHLI, OP_SHRI: begin
                            acc   <= alu_res;
                            carry <= alu_carry;
                        end
                        OP_LDA: acc <= mem;
                        OP_LDI: acc <= operand;
                        OP_STA: ram[ir[RAW-1:0]] <= acc;
                        OP_GOTO: begin
                            pc    <= ir[AW-1:0];
                            state <= ST_SYNC;
                        end
                        OP_SKIFZ, OP_SKIFN, OP_SKIFC: begin
                            if (skip_take) begin
                                pc    <= pc + AW'(1);
                                state <= ST_SYNC;
                            end
                        end
                        OP_CALL: begin
                            // Overflow leaves pc and stack untouched.
                            if (sp == SD_V) begin
                                fault  <= 1'b1;
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end else begin
                                stack[sp] <= pc;
                                sp        <= sp + SPW'(1);
                                pc        <= ir[AW-1:0];
                                state     <= ST_SYNC;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                fault  <= 1'b1;
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end else begin
                                pc    <= stack[sp - SPW'(1)];
                                sp    <= sp - SPW'(1);
                                state <= ST_SYNC;
                            end
                        end
                        OP_IN: acc <= indata;
                        OP_OUT: begin
                            outdata   <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                        default: ;
                    endcase
                end
                ST_SYNC: state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
